// File: rtl/display_scan.sv
// Stopwatch display back-end: shift-add-3 BCD conversion of seconds, atomic latch, 4-digit scan (SSS.D).
// Optional leading-zero blanking on hundreds/tens when DISPLAY_SCAN_BLANK_EN is defined.
module display_scan #(
  parameter int unsigned SCAN_DIV = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] cont_seg,
  input  logic [3:0] cont_dec,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  state_t      r_state;
  logic [9:0]  r_last_seg;
  logic [3:0]  r_last_dec;
  logic [9:0]  r_bin;
  logic [11:0] r_bcd;
  logic [3:0]  r_iter;
  logic [3:0]  r_dec_cap;
  logic [3:0]  r_d_hun, r_d_ten, r_d_uni, r_d_dec;
  logic        r_busy;

  logic [CW-1:0] r_scan;
  logic [1:0]    r_idx;

  logic [11:0] w_adj;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [6:0]  w_glyph;

  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_seg <= '0;
      r_last_dec <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
      r_dec_cap  <= '0;
      r_d_hun    <= '0;
      r_d_ten    <= '0;
      r_d_uni    <= '0;
      r_d_dec    <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Shadow registers keep the raw inputs so an out-of-range value held steady does not retrigger.
          if ({cont_seg, cont_dec} != {r_last_seg, r_last_dec}) begin
            r_last_seg <= cont_seg;
            r_last_dec <= cont_dec;
            r_bin      <= (cont_seg > 10'd999) ? 10'd999 : cont_seg;
            r_dec_cap  <= (cont_dec > 4'd9) ? 4'd9 : cont_dec;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_busy     <= 1'b1;
            r_state    <= CONV;
          end
        end
        CONV: begin
          r_bcd  <= {w_adj[10:0], r_bin[9]};
          r_bin  <= {r_bin[8:0], 1'b0};
          r_iter <= r_iter + 4'd1;
          if (r_iter == 4'd9) r_state <= LATCH;
        end
        LATCH: begin
          r_d_hun <= r_bcd[11:8];
          r_d_ten <= r_bcd[7:4];
          r_d_uni <= r_bcd[3:0];
          r_d_dec <= r_dec_cap;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else if (r_scan == CW'(SCAN_DIV - 1)) begin
      r_scan <= '0;
      r_idx  <= r_idx + 2'd1;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  always_comb begin
    case (r_idx)
      2'd0:    w_digit = r_d_dec;
      2'd1:    w_digit = r_d_uni;
      2'd2:    w_digit = r_d_ten;
      default: w_digit = r_d_hun;
    endcase
  end

`ifdef DISPLAY_SCAN_BLANK_EN
  assign w_blank = ((r_idx == 2'd3) && (r_d_hun == 4'd0)) ||
                   ((r_idx == 2'd2) && (r_d_hun == 4'd0) && (r_d_ten == 4'd0));
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_glyph = 7'b1111111;
    if (!w_blank) begin
      case (w_digit)
        4'd0:    w_glyph = 7'b1000000;
        4'd1:    w_glyph = 7'b1111001;
        4'd2:    w_glyph = 7'b0100100;
        4'd3:    w_glyph = 7'b0110000;
        4'd4:    w_glyph = 7'b0011001;
        4'd5:    w_glyph = 7'b0010010;
        4'd6:    w_glyph = 7'b0000010;
        4'd7:    w_glyph = 7'b1111000;
        4'd8:    w_glyph = 7'b0000000;
        4'd9:    w_glyph = 7'b0010000;
        default: w_glyph = 7'b1111111;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= 7'b1000000;
      an  <= 4'b1110;
      dp  <= 1'b1;
    end else begin
      seg <= w_glyph;
      an  <= ~(4'b0001 << r_idx);
      dp  <= (r_idx != 2'd1);
    end
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: vector table, corner-case sequences and random stimulus against a cycle-level model.
module tb_display_scan;

  localparam int SD = 8;

  localparam logic [6:0] G0 = 7'b1000000, G2 = 7'b0100100, G4 = 7'b0011001,
                         G5 = 7'b0010010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0010000;
`ifdef DISPLAY_SCAN_BLANK_EN
  localparam logic [6:0] GL = 7'b1111111;
`else
  localparam logic [6:0] GL = 7'b1000000;
`endif

  logic       clk, reset;
  logic [9:0] cont_seg;
  logic [3:0] cont_dec;
  logic [6:0] seg;
  logic       dp, busy;
  logic [3:0] an;

  display_scan #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .cont_seg(cont_seg), .cont_dec(cont_dec),
    .seg(seg), .dp(dp), .an(an), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: conversion is an 11-cycle countdown, digits come from decimal arithmetic.
  int m_cycle, m_busy, m_pv, m_pd;
  logic [9:0] m_last_s;
  logic [3:0] m_last_d;
  int m_disp[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_cycle = 0; m_busy = 0; m_pv = 0; m_pd = 0;
    m_last_s = '0; m_last_d = '0;
    for (int i = 0; i < 4; i++) m_disp[i] = 0;
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
      3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
      6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
      9: return 7'b0010000; default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_glyph(input int idx);
    bit blank = 1'b0;
`ifdef DISPLAY_SCAN_BLANK_EN
    blank = (idx == 3 && m_disp[3] == 0) || (idx == 2 && m_disp[3] == 0 && m_disp[2] == 0);
`endif
    return blank ? 7'b1111111 : glyph(m_disp[idx]);
  endfunction

  task automatic step();
    int idx;
    logic [6:0] es;
    logic [3:0] ea;
    logic ed, eb;
    @(posedge clk);
    idx = (m_cycle / SD) % 4;
    es = exp_glyph(idx);
    ea = 4'b1111; ea[idx] = 1'b0;
    ed = (idx != 1);
    if (m_busy == 0) begin
      if (cont_seg != m_last_s || cont_dec != m_last_d) begin
        m_last_s = cont_seg; m_last_d = cont_dec;
        m_pv = (cont_seg > 999) ? 999 : int'(cont_seg);
        m_pd = (cont_dec > 9) ? 9 : int'(cont_dec);
        m_busy = 11;
      end
    end else begin
      m_busy--;
      if (m_busy == 0) begin
        m_disp[3] = m_pv / 100;
        m_disp[2] = (m_pv / 10) % 10;
        m_disp[1] = m_pv % 10;
        m_disp[0] = m_pd;
      end
    end
    m_cycle++;
    eb = (m_busy != 0);
    #1;
    chk("seg", 32'(seg), 32'(es));
    chk("an", 32'(an), 32'(ea));
    chk("dp", 32'(dp), 32'(ed));
    chk("busy", 32'(busy), 32'(eb));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin step(); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL conv_timeout actual=busy required=idle t=%0t", $time);
    end
  endtask

  typedef struct {
    logic [9:0] s;
    logic [3:0] d;
    logic [6:0] g_hun, g_ten, g_uni, g_dec;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int gap, nb, hold;
    bit seen_fall;

    tbl[0] = '{827, 4, G8, G2, G7, G4};
    tbl[1] = '{1023, 12, G9, G9, G9, G9};
    tbl[2] = '{7, 0, GL, GL, G7, G0};
    tbl[3] = '{40, 5, GL, G4, G0, G5};
    tbl[4] = '{0, 0, GL, GL, G0, G0};

    reset = 1'b1; cont_seg = '0; cont_dec = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_seg", 32'(seg), 32'(7'b1000000));
    chk("rst_an", 32'(an), 32'(4'b1110));
    chk("rst_dp", 32'(dp), 32'(1'b1));
    chk("rst_busy", 32'(busy), 32'(1'b0));

    nb = 0;
    for (int i = 0; i < 4 * SD; i++) begin step(); if (busy) nb++; end
    chk("idle_busy_cycles", 32'(nb), 32'd0);

    for (int v = 0; v < 5; v++) begin
      cont_seg = tbl[v].s; cont_dec = tbl[v].d;
      step();
      chk("tbl_busy_start", 32'(busy), 32'd1);
      nb = 1;
      while (busy && nb < 40) begin step(); if (busy) nb++; end
      chk("tbl_busy_len", 32'(nb), 32'd11);
      step();
      for (int i = 0; i < 4 * SD; i++) begin
        step();
        case (an)
          4'b0111: chk("tbl_hun", 32'(seg), 32'(tbl[v].g_hun));
          4'b1011: chk("tbl_ten", 32'(seg), 32'(tbl[v].g_ten));
          4'b1101: chk("tbl_uni", 32'(seg), 32'(tbl[v].g_uni));
          4'b1110: chk("tbl_dec", 32'(seg), 32'(tbl[v].g_dec));
          default: chk("tbl_an_onehot", 32'(an), 32'hF);
        endcase
      end
      if (v == 1) begin
        nb = 0;
        for (int i = 0; i < 20; i++) begin step(); if (busy) nb++; end
        chk("clamp_no_reconv", 32'(nb), 32'd0);
      end
    end

    cont_seg = 10'd4; cont_dec = 4'd0;
    step(); wait_idle(); step();
    cont_seg = 10'd5;
    step(); step(); step();
    cont_seg = 10'd6;
    gap = 0; seen_fall = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!busy && (seen_fall || i < 15)) begin seen_fall = 1'b1; gap++; end
      if (busy && seen_fall) break;
    end
    chk("back_to_back_gap", 32'(gap), 32'd1);
    wait_idle();
    for (int i = 0; i < 4 * SD; i++) step();

    cont_seg = 10'd123; cont_dec = 4'd7;
    step(); step(); step();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_an", 32'(an), 32'(4'b1110));
    chk("arst_seg", 32'(seg), 32'(7'b1000000));
    chk("arst_dp", 32'(dp), 32'd1);
    cont_seg = '0; cont_dec = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4 * SD; i++) step();

    for (int r = 0; r < 200; r++) begin
      if ($urandom_range(0, 3) != 0) begin
        cont_seg = 10'($urandom_range(0, 1023));
        cont_dec = 4'($urandom_range(0, 15));
      end
      hold = $urandom_range(1, 20);
      for (int i = 0; i < hold; i++) step();
    end
    wait_idle();
    for (int i = 0; i < 4 * SD; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
